// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - instruction queue between dual-word fetch and decode
// Captures a 64-bit fetch pair one cycle after its request and holds it as two {pc, inst} entries.
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 34
`endif

module inst_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [`IF_TO_ID_WD-1:0] if_to_id_bus,
  input  logic [63:0]             inst_sram_rdata,
  input  logic [1:0]              id_pop,
  output logic                    inst0_valid,
  output logic [31:0]             inst0_pc,
  output logic [31:0]             inst0,
  output logic                    inst1_valid,
  output logic [31:0]             inst1_pc,
  output logic [31:0]             inst1,
  output logic                    stallreq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - 4);

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW-1:0] rd_ptr1, wr_ptr1;
  logic [CW-1:0] count;
  logic [CW-1:0] pop_ext, pe;
  logic          req_valid_q, req_discard_q;
  logic [31:0]   req_pc_q;
  logic          wr;

  assign rd_ptr1 = rd_ptr + PW'(1);
  assign wr_ptr1 = wr_ptr + PW'(1);
  assign pop_ext = CW'(id_pop);
  // ID may ask for more than is held; only what exists is retired
  assign pe      = (pop_ext > count) ? count : pop_ext;
  assign wr      = req_valid_q & ~req_discard_q & ~flush;

  always_ff @(posedge clk) begin
    req_discard_q <= if_to_id_bus[33];
    req_pc_q      <= if_to_id_bus[31:0];
    if (rst || flush) begin
      req_valid_q <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      req_valid_q <= if_to_id_bus[32];
      if (wr)
        wr_ptr <= wr_ptr + PW'(2);
      rd_ptr <= rd_ptr + pe[PW-1:0];
      count  <= count + (wr ? CW'(2) : CW'(0)) - pe;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      pc_mem[wr_ptr]    <= req_pc_q;
      inst_mem[wr_ptr]  <= inst_sram_rdata[31:0];
      pc_mem[wr_ptr1]   <= req_pc_q + 32'd4;
      inst_mem[wr_ptr1] <= inst_sram_rdata[63:32];
    end
  end

  // Outputs show stored entries only; a same-cycle write is not bypassed
  assign inst0_valid = (count != '0);
  assign inst1_valid = (count >= CW'(2));
  assign inst0_pc    = inst0_valid ? pc_mem[rd_ptr]    : 32'd0;
  assign inst0       = inst0_valid ? inst_mem[rd_ptr]  : 32'd0;
  assign inst1_pc    = inst1_valid ? pc_mem[rd_ptr1]   : 32'd0;
  assign inst1       = inst1_valid ? inst_mem[rd_ptr1] : 32'd0;

  // Leaves room for this cycle's write plus the response to this cycle's fetch
  assign stallreq = (count >= STALL_AT);

endmodule

// File: tb/tb_inst_fifo.sv
// tb/tb_inst_fifo.sv - self-checking bench for inst_fifo
// Directed table, corner sequences and randomized traffic against a queue-based model.
module tb_inst_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [33:0] if_to_id_bus;
  logic [63:0] inst_sram_rdata;
  logic [1:0]  id_pop;
  logic        inst0_valid, inst1_valid, stallreq;
  logic [31:0] inst0_pc, inst0, inst1_pc, inst1;

  always #5 clk = ~clk;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .if_to_id_bus(if_to_id_bus),
    .inst_sram_rdata(inst_sram_rdata), .id_pop(id_pop),
    .inst0_valid(inst0_valid), .inst0_pc(inst0_pc), .inst0(inst0),
    .inst1_valid(inst1_valid), .inst1_pc(inst1_pc), .inst1(inst1),
    .stallreq(stallreq)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    bit          ce;
    bit          disc;
    logic [31:0] pc;
    logic [63:0] rdata;
    logic [1:0]  pop;
    bit          v0;
    logic [31:0] pc0;
    logic [31:0] i0;
    bit          v1;
    logic [31:0] pc1;
    logic [31:0] i1;
    bit          stall;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t q[$];
  bit   m_rv, m_rd, m_stall_prev;
  logic [31:0] m_rpc;
  int   peak;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit c, input bit d, input logic [31:0] p,
                       input logic [63:0] rd, input logic [1:0] pp, input bit f);
    if_to_id_bus    = {d, c, p};
    inst_sram_rdata = rd;
    id_pop          = pp;
    flush           = f;
    #4;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".inst0_valid"}, 32'(inst0_valid), 32'(q.size() >= 1));
    chk({tag, ".inst0_pc"}, inst0_pc, q.size() >= 1 ? q[0].pc : 32'd0);
    chk({tag, ".inst0"}, inst0, q.size() >= 1 ? q[0].inst : 32'd0);
    chk({tag, ".inst1_valid"}, 32'(inst1_valid), 32'(q.size() >= 2));
    chk({tag, ".inst1_pc"}, inst1_pc, q.size() >= 2 ? q[1].pc : 32'd0);
    chk({tag, ".inst1"}, inst1, q.size() >= 2 ? q[1].inst : 32'd0);
    chk({tag, ".stallreq"}, 32'(stallreq), 32'(q.size() >= DEPTH - 4));
  endtask

  // Model advances at the clock edge using the inputs held during the cycle
  task automatic advance();
    int pe;
    bit w;
    @(posedge clk);
    m_stall_prev = (q.size() >= DEPTH - 4);
    if (rst || flush) begin
      q.delete();
      m_rv = 1'b0;
      if (rst) m_stall_prev = 1'b0;
    end else begin
      pe = (int'(id_pop) > q.size()) ? q.size() : int'(id_pop);
      w  = m_rv && !m_rd;
      if (w) begin
        n_tests++;
        if (q.size() + 2 - pe > DEPTH) begin
          n_fail++;
          $display("FAIL overflow: count would be %0d, limit %0d", q.size() + 2 - pe, DEPTH);
        end
      end
      repeat (pe) void'(q.pop_front());
      if (w) begin
        q.push_back('{pc: m_rpc, inst: inst_sram_rdata[31:0]});
        q.push_back('{pc: m_rpc + 32'd4, inst: inst_sram_rdata[63:32]});
      end
      m_rv = if_to_id_bus[32];
    end
    m_rd  = if_to_id_bus[33];
    m_rpc = if_to_id_bus[31:0];
    if (q.size() > peak) peak = q.size();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 64'd0, 2'd0, 1'b0);
    advance();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    bit c;
    rst = 1'b1; flush = 1'b0; if_to_id_bus = '0; inst_sram_rdata = '0; id_pop = '0;
    m_rv = 1'b0; m_rd = 1'b0; m_rpc = '0; m_stall_prev = 1'b0; peak = 0;

    tbl[0] = '{1, 0, 32'hbfc00000, 64'h0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0};
    tbl[1] = '{0, 0, 32'h0, 64'h11111111_00000000, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0};
    tbl[2] = '{1, 1, 32'h100, 64'h0, 2'd0, 1, 32'hbfc00000, 32'h0, 1, 32'hbfc00004, 32'h11111111, 0};
    tbl[3] = '{1, 0, 32'h200, 64'hdeaddead_deaddead, 2'd0, 1, 32'hbfc00000, 32'h0, 1, 32'hbfc00004, 32'h11111111, 0};
    tbl[4] = '{0, 0, 32'h0, 64'hbbbbbbbb_aaaaaaaa, 2'd2, 1, 32'hbfc00000, 32'h0, 1, 32'hbfc00004, 32'h11111111, 0};
    tbl[5] = '{0, 0, 32'h0, 64'h0, 2'd0, 1, 32'h200, 32'haaaaaaaa, 1, 32'h204, 32'hbbbbbbbb, 0};
    tbl[6] = '{0, 0, 32'h0, 64'h0, 2'd1, 1, 32'h200, 32'haaaaaaaa, 1, 32'h204, 32'hbbbbbbbb, 0};
    tbl[7] = '{0, 0, 32'h0, 64'h0, 2'd2, 1, 32'h204, 32'hbbbbbbbb, 0, 32'h0, 32'h0, 0};
    tbl[8] = '{0, 0, 32'h0, 64'h0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 0};

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].ce, tbl[i].disc, tbl[i].pc, tbl[i].rdata, tbl[i].pop, 1'b0);
      chk($sformatf("tbl%0d.inst0_valid", i), 32'(inst0_valid), 32'(tbl[i].v0));
      chk($sformatf("tbl%0d.inst0_pc", i), inst0_pc, tbl[i].pc0);
      chk($sformatf("tbl%0d.inst0", i), inst0, tbl[i].i0);
      chk($sformatf("tbl%0d.inst1_valid", i), 32'(inst1_valid), 32'(tbl[i].v1));
      chk($sformatf("tbl%0d.inst1_pc", i), inst1_pc, tbl[i].pc1);
      chk($sformatf("tbl%0d.inst1", i), inst1, tbl[i].i1);
      chk($sformatf("tbl%0d.stallreq", i), 32'(stallreq), 32'(tbl[i].stall));
      advance();
    end

    // Wrap: queue is empty with both pointers parked mid-buffer
    exp_pc = 32'h1000;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0)
        drive(1'b1, 1'b0, 32'h1000 + 32'(8 * (i / 2)), {$urandom, $urandom}, 2'd0, 1'b0);
      else
        drive(1'b0, 1'b0, 32'd0, {$urandom, $urandom}, 2'd2, 1'b0);
      check_model("wrap");
      if (i % 2 == 1 && q.size() >= 2) begin
        chk("wrap.seq_pc0", inst0_pc, exp_pc);
        chk("wrap.seq_pc1", inst1_pc, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd8;
      end
      advance();
    end
    chk("wrap.pairs_seen", exp_pc, 32'h1000 + 32'd72);

    // Fill: IF drops ce one cycle after seeing stallreq
    do_reset();
    peak = 0;
    for (int i = 0; i < 12; i++) begin
      drive(!m_stall_prev, 1'b0, 32'h2000 + 32'(8 * i), {$urandom, $urandom}, 2'd0, 1'b0);
      check_model("fill");
      advance();
    end
    chk("fill.peak", 32'(peak), 32'(DEPTH));
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'd0, 64'd0, 2'd2, 1'b0);
      check_model("drain");
      advance();
    end

    // Flush with five entries held and a fetch in flight
    do_reset();
    drive(1'b1, 1'b0, 32'h3000, 64'd0, 2'd0, 1'b0); advance();
    drive(1'b1, 1'b0, 32'h3008, 64'h0000000b_0000000a, 2'd0, 1'b0); advance();
    drive(1'b1, 1'b0, 32'h3010, 64'h0000000d_0000000c, 2'd0, 1'b0); advance();
    drive(1'b0, 1'b0, 32'h0, 64'h0000000f_0000000e, 2'd0, 1'b0); advance();
    drive(1'b1, 1'b0, 32'h3018, 64'd0, 2'd1, 1'b0);
    chk("flush.pre_pc0", inst0_pc, 32'h3000);
    advance();
    chk("flush.pre_size", 32'(q.size()), 32'd5);
    drive(1'b0, 1'b0, 32'h0, 64'h12345678_9abcdef0, 2'd2, 1'b1);
    chk("flush.same_cycle_valid", 32'(inst0_valid), 32'd1);
    advance();
    drive(1'b0, 1'b0, 32'h0, 64'hcafef00d_cafef00d, 2'd0, 1'b0);
    chk("flush.next_inst0_valid", 32'(inst0_valid), 32'd0);
    chk("flush.next_inst1_valid", 32'(inst1_valid), 32'd0);
    chk("flush.next_stallreq", 32'(stallreq), 32'd0);
    advance();
    drive(1'b0, 1'b0, 32'h0, 64'd0, 2'd0, 1'b0);
    chk("flush.stale_dropped", 32'(inst0_valid), 32'd0);
    check_model("flush");
    advance();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      c = !m_stall_prev && ($urandom % 4 != 0);
      drive(c, ($urandom % 8) == 0, $urandom & 32'hffff_fff8, {$urandom, $urandom},
            2'($urandom_range(0, 2)), ($urandom % 32) == 0);
      check_model("rand");
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
